// File: rtl/simd_wb_arbiter.sv
// Per-source result FIFOs feeding NUM_WB vector regfile write ports.
// Heads are granted round-robin and land in registered write-port slots.
module simd_wb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_WB     = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 128
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data_i,
    output logic [NUM_SRC-1:0]         src_ready_o,
    output logic [NUM_WB-1:0]          wb_enable_o,
    output logic [NUM_WB*ADDR_W-1:0]   wb_addr_o,
    output logic [NUM_WB*DATA_W-1:0]   wb_data_o,
    output logic                       fifo_empty_o
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]     r_wptr    [NUM_SRC];
    logic [PW-1:0]     r_rptr    [NUM_SRC];
    logic [ADDR_W-1:0] r_addrMem [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] r_dataMem [NUM_SRC][FIFO_DEPTH];
    logic [SW-1:0]     r_rrPtr;
    logic [NUM_WB-1:0]        r_wbEnable;
    logic [NUM_WB*ADDR_W-1:0] r_wbAddr;
    logic [NUM_WB*DATA_W-1:0] r_wbData;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pick;
    logic [NUM_WB-1:0]  w_slotValid;
    logic [SW-1:0]      w_slotSrc  [NUM_WB];
    logic [ADDR_W-1:0]  w_headAddr [NUM_WB];
    logic [DATA_W-1:0]  w_headData [NUM_WB];
    logic [SW-1:0]      w_rrNext;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            w_full[s]  = (r_wptr[s][PW-1] != r_rptr[s][PW-1]) &&
                         (r_wptr[s][IW-1:0] == r_rptr[s][IW-1:0]);
            w_empty[s] = (r_wptr[s] == r_rptr[s]);
        end
    end

    assign src_ready_o = ~w_full & {NUM_SRC{rstn_i}};
    assign w_push      = src_valid_i & src_ready_o & {NUM_SRC{~flush_i}};

    // Rotate the scan start to rr_ptr; the k-th non-empty FIFO found owns slot k.
    always_comb begin
        int          cnt;
        logic [SW:0] sum;
        logic [SW-1:0] idx;
        w_pick      = '0;
        w_slotValid = '0;
        w_rrNext    = r_rrPtr;
        cnt         = 0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            w_slotSrc[k] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, r_rrPtr} + (SW+1)'(i);
            if (sum >= (SW+1)'(NUM_SRC)) begin
                sum = sum - (SW+1)'(NUM_SRC);
            end
            idx = sum[SW-1:0];
            if (!w_empty[idx] && cnt < NUM_WB) begin
                w_pick[idx] = 1'b1;
                for (int k = 0; k < NUM_WB; k++) begin
                    if (k == cnt) begin
                        w_slotValid[k] = 1'b1;
                        w_slotSrc[k]   = idx;
                    end
                end
                w_rrNext = (idx == SW'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
                cnt      = cnt + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            w_headAddr[k] = r_addrMem[w_slotSrc[k]][r_rptr[w_slotSrc[k]][IW-1:0]];
            w_headData[k] = r_dataMem[w_slotSrc[k]][r_rptr[w_slotSrc[k]][IW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_push[s]) begin
                r_addrMem[s][r_wptr[s][IW-1:0]] <= src_addr_i[s*ADDR_W +: ADDR_W];
                r_dataMem[s][r_wptr[s][IW-1:0]] <= src_data_i[s*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
            r_rrPtr    <= '0;
            r_wbEnable <= '0;
            r_wbAddr   <= '0;
            r_wbData   <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
            r_rrPtr    <= '0;
            r_wbEnable <= '0;
            r_wbAddr   <= '0;
            r_wbData   <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_push[s]) begin
                    r_wptr[s] <= r_wptr[s] + 1'b1;
                end
                if (w_pick[s]) begin
                    r_rptr[s] <= r_rptr[s] + 1'b1;
                end
            end
            if (|w_pick) begin
                r_rrPtr <= w_rrNext;
            end
            r_wbEnable <= w_slotValid;
            for (int k = 0; k < NUM_WB; k++) begin
                r_wbAddr[k*ADDR_W +: ADDR_W] <= w_slotValid[k] ? w_headAddr[k] : '0;
                r_wbData[k*DATA_W +: DATA_W] <= w_slotValid[k] ? w_headData[k] : '0;
            end
        end
    end

    assign wb_enable_o  = r_wbEnable;
    assign wb_addr_o    = r_wbAddr;
    assign wb_data_o    = r_wbData;
    assign fifo_empty_o = (&w_empty) && !(|r_wbEnable);

endmodule

// File: tb/tb_simd_wb_arbiter.sv
// Self-checking bench for simd_wb_arbiter: directed scenarios plus random traffic,
// compared against a queue-based reference model of the write-back arbiter.
module tb_simd_wb_arbiter;

    localparam int NS = 4;
    localparam int NW = 2;
    localparam int DEPTH = 2;
    localparam int AW = 6;
    localparam int DW = 128;

    logic               clk_i;
    logic               rstn_i;
    logic               flush_i;
    logic [NS-1:0]      src_valid_i;
    logic [NS*AW-1:0]   src_addr_i;
    logic [NS*DW-1:0]   src_data_i;
    logic [NS-1:0]      src_ready_o;
    logic [NW-1:0]      wb_enable_o;
    logic [NW*AW-1:0]   wb_addr_o;
    logic [NW*DW-1:0]   wb_data_o;
    logic               fifo_empty_o;

    simd_wb_arbiter #(
        .NUM_SRC(NS), .NUM_WB(NW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .src_valid_i(src_valid_i), .src_addr_i(src_addr_i), .src_data_i(src_data_i),
        .src_ready_o(src_ready_o), .wb_enable_o(wb_enable_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .fifo_empty_o(fifo_empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q [NS][$];
    int            rr;
    logic [NW-1:0] expEn;
    logic [AW-1:0] expA [NW];
    logic [DW-1:0] expD [NW];

    int compared;
    int mismatched;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelAllEmpty();
        for (int s = 0; s < NS; s++) begin
            if (q[s].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelClear();
        for (int s = 0; s < NS; s++) q[s].delete();
        rr    = 0;
        expEn = '0;
        for (int k = 0; k < NW; k++) begin
            expA[k] = '0;
            expD[k] = '0;
        end
    endtask

    // One clock of the reference: grant up to NW heads scanning from rr, then accept pushes
    // against the occupancy seen before the pops.
    task automatic modelStep(input logic [NS-1:0] v, input logic [NS*AW-1:0] a,
                             input logic [NS*DW-1:0] d, input logic f, input logic [NS-1:0] rdy);
        int     cnt;
        int     last;
        int     s;
        bit     picked [NS];
        ent_t   e;
        if (f) begin
            modelClear();
            return;
        end
        expEn = '0;
        for (int k = 0; k < NW; k++) begin
            expA[k] = '0;
            expD[k] = '0;
        end
        cnt  = 0;
        last = 0;
        for (int i = 0; i < NS; i++) picked[i] = 1'b0;
        for (int i = 0; i < NS; i++) begin
            s = (rr + i) % NS;
            if (q[s].size() > 0 && cnt < NW) begin
                expEn[cnt] = 1'b1;
                expA[cnt]  = q[s][0].a;
                expD[cnt]  = q[s][0].d;
                picked[s]  = 1'b1;
                last       = s;
                cnt++;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (picked[i]) void'(q[i].pop_front());
            if (v[i] && rdy[i]) begin
                e.a = a[i*AW +: AW];
                e.d = d[i*DW +: DW];
                q[i].push_back(e);
            end
        end
        if (cnt > 0) rr = (last + 1) % NS;
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle, then the registered
    // write ports just after the edge.
    task automatic applyStimulus(input logic [NS-1:0] v, input logic [NS*AW-1:0] a,
                                 input logic [NS*DW-1:0] d, input logic f);
        logic [NS-1:0] rdy;
        src_valid_i = v;
        src_addr_i  = a;
        src_data_i  = d;
        flush_i     = f;
        @(negedge clk_i);
        for (int s = 0; s < NS; s++) rdy[s] = (q[s].size() < DEPTH);
        checkOutput("src_ready", DW'(src_ready_o), DW'(rdy));
        checkOutput("fifo_empty", DW'(fifo_empty_o), DW'(modelAllEmpty() && expEn == '0));
        modelStep(v, a, d, f, rdy);
        @(posedge clk_i);
        #1;
        checkOutput("wb_enable", DW'(wb_enable_o), DW'(expEn));
        if (!f) begin
            for (int k = 0; k < NW; k++) begin
                checkOutput($sformatf("wb_addr[%0d]", k), DW'(wb_addr_o[k*AW +: AW]), DW'(expA[k]));
                checkOutput($sformatf("wb_data[%0d]", k), wb_data_o[k*DW +: DW], expD[k]);
            end
        end
    endtask

    function automatic logic [NS*DW-1:0] randData();
        logic [NS*DW-1:0] r;
        for (int i = 0; i < NS*DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NS*AW-1:0] randAddr();
        logic [NS*AW-1:0] r;
        for (int i = 0; i < NS; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [NS*AW-1:0] av;
        logic [NS*DW-1:0] dv;
        compared    = 0;
        mismatched  = 0;
        rstn_i      = 1'b0;
        flush_i     = 1'b0;
        src_valid_i = '0;
        src_addr_i  = '0;
        src_data_i  = '0;
        modelClear();

        #12;
        checkOutput("reset_ready", DW'(src_ready_o), '0);
        checkOutput("reset_empty", DW'(fifo_empty_o), DW'(1'b1));
        checkOutput("reset_wb_enable", DW'(wb_enable_o), '0);
        checkOutput("reset_wb_addr", DW'(wb_addr_o), '0);
        checkOutput("reset_wb_data", wb_data_o[DW-1:0], '0);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] single push from source 1");
        av = '0; dv = '0;
        av[1*AW +: AW] = 6'd5;
        dv[1*DW +: DW] = {16{8'hA5}};
        applyStimulus(4'b0010, av, dv, 1'b0);
        idle(3);

        $display("[TB] all sources at once");
        av = {6'd13, 6'd12, 6'd11, 6'd10};
        applyStimulus(4'b1111, av, randData(), 1'b0);
        idle(3);

        $display("[TB] source 0 streaming");
        for (int i = 0; i < 8; i++) begin
            av = '0;
            av[AW-1:0] = AW'(i + 20);
            applyStimulus(4'b0001, av, randData(), 1'b0);
        end
        idle(2);

        $display("[TB] build occupancy then flush with source 3 valid");
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, randAddr(), randData(), 1'b0);
        applyStimulus(4'b0101, randAddr(), randData(), 1'b0);
        applyStimulus(4'b1000, randAddr(), randData(), 1'b1);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(NS'($urandom), randAddr(), randData(), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] asynchronous reset mid-burst");
        for (int i = 0; i < 4; i++) applyStimulus(4'b1111, randAddr(), randData(), 1'b0);
        #2;
        rstn_i = 1'b0;
        #1;
        modelClear();
        checkOutput("async_rst_wb_enable", DW'(wb_enable_o), '0);
        checkOutput("async_rst_ready", DW'(src_ready_o), '0);
        checkOutput("async_rst_empty", DW'(fifo_empty_o), DW'(1'b1));
        src_valid_i = '0;
        @(negedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("post_rst_ready", DW'(src_ready_o), DW'({NS{1'b1}}));
        idle(3);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(NS'($urandom), randAddr(), randData(), ($urandom_range(0, 29) == 0));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
